// File: rtl/wb_pkg.sv
// Shared encodings for the RV32I writeback stage.
// Result-source selects, load funct3 codes and the stage-register state type.
package wb_pkg;

   localparam logic [1:0] WB_SEL_PC4 = 2'd0;
   localparam logic [1:0] WB_SEL_ALU = 2'd1;
   localparam logic [1:0] WB_SEL_MEM = 2'd2;
   localparam logic [1:0] WB_SEL_CSR = 2'd3;

   localparam logic [2:0] LD_LB  = 3'b000;
   localparam logic [2:0] LD_LH  = 3'b001;
   localparam logic [2:0] LD_LW  = 3'b010;
   localparam logic [2:0] LD_LBU = 3'b100;
   localparam logic [2:0] LD_LHU = 3'b101;

   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } wb_state_e;

endpackage

// File: rtl/wb_load_ext.sv
// Combinational load alignment, sign/zero extension and misalign detection.
// Only a 32-bit datapath is extended; other widths pass the word through.
module wb_load_ext
   import wb_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [2:0]      funct3,
   input  logic [1:0]      off,
   input  logic [XLEN-1:0] word,
   output logic [XLEN-1:0] data,
   output logic            misalign
);

   always_comb begin
      misalign = 1'b0;
      case (funct3)
         LD_LB, LD_LBU: misalign = 1'b0;
         LD_LH, LD_LHU: misalign = off[0];
         default:       misalign = (off != 2'b00);
      endcase
   end

   generate
      if (XLEN == 32) begin : g_ext
         logic [7:0]  b;
         logic [15:0] h;

         assign b = word[{off, 3'b000} +: 8];
         assign h = word[{off[1], 4'b0000} +: 16];

         always_comb begin
            data = word;
            case (funct3)
               LD_LB:   data = {{(XLEN-8){b[7]}}, b};
               LD_LBU:  data = {{(XLEN-8){1'b0}}, b};
               LD_LH:   data = {{(XLEN-16){h[15]}}, h};
               LD_LHU:  data = {{(XLEN-16){1'b0}}, h};
               default: data = word;
            endcase
         end
      end else begin : g_pass
         assign data = word;
      end
   endgenerate

endmodule

// File: rtl/wb_stage.sv
// RV32I writeback stage: single registered entry driving the register-file write port.
// Define WB_RETIRE_CNT_EN to add the retire_cnt output and its counter.
module wb_stage
   import wb_pkg::*;
#(
   parameter int XLEN       = 32,
   parameter int REG_ADDR_W = 5,
   parameter int LINK_REG   = 1
`ifdef WB_RETIRE_CNT_EN
  ,parameter int CNT_W      = 64
`endif
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [1:0]            in_wb_sel,
   input  logic                  in_wa_sel,
   input  logic [REG_ADDR_W-1:0] in_rd,
   input  logic                  in_rf_we,
   input  logic [XLEN-1:0]       in_pc4,
   input  logic [XLEN-1:0]       in_alu,
   input  logic [XLEN-1:0]       in_mem_rdata,
   input  logic [XLEN-1:0]       in_csr,
   input  logic [2:0]            in_ld_funct3,
   input  logic [1:0]            in_ld_off,
   input  logic                  flush,
   input  logic                  rf_stall,
   output logic                  rf_we,
   output logic [REG_ADDR_W-1:0] rf_waddr,
   output logic [XLEN-1:0]       rf_wdata,
   output logic                  misalign_err
`ifdef WB_RETIRE_CNT_EN
  ,output logic [CNT_W-1:0]      retire_cnt
`endif
);

   wb_state_e             state_q, state_d;
   logic                  we_q, we_d;
   logic                  mis_q, mis_d;
   logic [REG_ADDR_W-1:0] waddr_q, waddr_d;
   logic [XLEN-1:0]       wdata_q, wdata_d;

   logic [XLEN-1:0]       ld_data;
   logic                  ld_mis;
   logic [XLEN-1:0]       wdata_sel;
   logic [REG_ADDR_W-1:0] waddr_sel;
   logic                  mis_sel;
   logic                  full, retire, accept;

   wb_load_ext #(.XLEN(XLEN)) u_load_ext (
      .funct3   (in_ld_funct3),
      .off      (in_ld_off),
      .word     (in_mem_rdata),
      .data     (ld_data),
      .misalign (ld_mis)
   );

   assign full      = (state_q == ST_FULL);
   assign in_ready  = !full || !rf_stall;
   assign retire    = full && !rf_stall;
   assign accept    = in_valid && in_ready && !flush;
   assign waddr_sel = in_wa_sel ? in_rd : REG_ADDR_W'(LINK_REG);
   assign mis_sel   = (in_wb_sel == WB_SEL_MEM) && ld_mis;

   always_comb begin
      wdata_sel = in_alu;
      unique case (in_wb_sel)
         WB_SEL_PC4: wdata_sel = in_pc4;
         WB_SEL_ALU: wdata_sel = in_alu;
         WB_SEL_MEM: wdata_sel = ld_data;
         WB_SEL_CSR: wdata_sel = in_csr;
         default:    wdata_sel = in_alu;
      endcase
   end

   // flush wins over both accept and retire
   always_comb begin
      state_d = state_q;
      we_d    = we_q;
      mis_d   = mis_q;
      waddr_d = waddr_q;
      wdata_d = wdata_q;
      if (flush) begin
         state_d = ST_EMPTY;
      end else if (accept) begin
         state_d = ST_FULL;
         we_d    = in_rf_we;
         mis_d   = mis_sel;
         waddr_d = waddr_sel;
         wdata_d = wdata_sel;
      end else if (retire) begin
         state_d = ST_EMPTY;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_EMPTY;
         we_q    <= 1'b0;
         mis_q   <= 1'b0;
         waddr_q <= '0;
         wdata_q <= '0;
      end else begin
         state_q <= state_d;
         we_q    <= we_d;
         mis_q   <= mis_d;
         waddr_q <= waddr_d;
         wdata_q <= wdata_d;
      end
   end

   assign rf_we        = full && we_q && (waddr_q != '0) && !mis_q;
   assign rf_waddr     = waddr_q;
   assign rf_wdata     = wdata_q;
   assign misalign_err = full && mis_q;

`ifdef WB_RETIRE_CNT_EN
   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (retire && !flush) cnt_d = cnt_q + 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

   assign retire_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Scoreboard bench for wb_stage: directed spec cases plus randomized traffic
// checked against an arithmetic reference model.
module tb_wb_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [1:0]  in_wb_sel;
   logic        in_wa_sel;
   logic [4:0]  in_rd;
   logic        in_rf_we;
   logic [31:0] in_pc4, in_alu, in_mem_rdata, in_csr;
   logic [2:0]  in_ld_funct3;
   logic [1:0]  in_ld_off;
   logic        flush;
   logic        rf_stall;
   logic        rf_we;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdata;
   logic        misalign_err;
`ifdef WB_RETIRE_CNT_EN
   logic [63:0] retire_cnt;
`endif

   wb_stage dut (
      .clk          (clk),
      .rst          (rst),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_wb_sel    (in_wb_sel),
      .in_wa_sel    (in_wa_sel),
      .in_rd        (in_rd),
      .in_rf_we     (in_rf_we),
      .in_pc4       (in_pc4),
      .in_alu       (in_alu),
      .in_mem_rdata (in_mem_rdata),
      .in_csr       (in_csr),
      .in_ld_funct3 (in_ld_funct3),
      .in_ld_off    (in_ld_off),
      .flush        (flush),
      .rf_stall     (rf_stall),
      .rf_we        (rf_we),
      .rf_waddr     (rf_waddr),
      .rf_wdata     (rf_wdata),
      .misalign_err (misalign_err)
`ifdef WB_RETIRE_CNT_EN
     ,.retire_cnt   (retire_cnt)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      bit          mis;
      logic [4:0]  waddr;
      logic [31:0] wdata;
   } exp_t;

   exp_t        q[$];
   bit          mfull;
   logic [63:0] mcnt;
   int          checks = 0;
   int          errors = 0;

   task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] ref_load(logic [2:0] f3, logic [1:0] off, logic [31:0] w);
      logic [31:0] b, h;
      b = (w >> (int'(off) * 8)) & 32'hFF;
      h = (w >> ((int'(off) / 2) * 16)) & 32'hFFFF;
      case (f3)
         3'd0:    return (b >= 128) ? b + 32'hFFFF_FF00 : b;
         3'd1:    return (h >= 32768) ? h + 32'hFFFF_0000 : h;
         3'd4:    return b;
         3'd5:    return h;
         default: return w;
      endcase
   endfunction

   function automatic bit ref_mis(logic [2:0] f3, logic [1:0] off);
      int size;
      if (f3 == 3'd0 || f3 == 3'd4)      size = 1;
      else if (f3 == 3'd1 || f3 == 3'd5) size = 2;
      else                               size = 4;
      return (int'(off) % size) != 0;
   endfunction

   // Applies the edge that just occurred to the model, using the inputs held over it.
   task automatic model_update();
      bit          rdy;
      exp_t        e;
      logic [4:0]  wa;
      logic [31:0] d;
      bit          mis;
      if (rst) return;
      rdy = !mfull || !rf_stall;
      if (flush) begin
         q.delete();
         mfull = 0;
      end else begin
         if (mfull && !rf_stall) mcnt++;
         if (in_valid && rdy) begin
            mfull = 1;
            wa  = in_wa_sel ? in_rd : 5'd1;
            mis = (in_wb_sel == 2'd2) && ref_mis(in_ld_funct3, in_ld_off);
            case (in_wb_sel)
               2'd0:    d = in_pc4;
               2'd1:    d = in_alu;
               2'd2:    d = ref_load(in_ld_funct3, in_ld_off, in_mem_rdata);
               default: d = in_csr;
            endcase
            if (mis || (in_rf_we && wa != 5'd0)) begin
               e.mis = mis; e.waddr = wa; e.wdata = d;
               q.push_back(e);
            end
         end else if (mfull && !rf_stall) begin
            mfull = 0;
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_update();
      #1;
   endtask

   task automatic set_in(bit v, logic [1:0] sel, bit wa, logic [4:0] rd, bit we,
                         logic [31:0] d, logic [2:0] f3, logic [1:0] off);
      in_valid = v; in_wb_sel = sel; in_wa_sel = wa; in_rd = rd; in_rf_we = we;
      in_pc4 = d; in_alu = d; in_mem_rdata = d; in_csr = d;
      in_ld_funct3 = f3; in_ld_off = off;
   endtask

   task automatic do_reset_now();
      rst = 1'b1;
      q.delete();
      mfull = 0;
      mcnt = '0;
   endtask

   // Monitor: compares presented outputs against the scoreboard head.
   always @(negedge clk) begin
      if (!rst) begin
         chk("in_ready", in_ready, !mfull || !rf_stall);
         if (rf_we || misalign_err) begin
            if (q.size() == 0) begin
               chk("unexpected_out", {rf_we, misalign_err}, 2'b00);
            end else begin
               chk("rf_we", rf_we, !q[0].mis);
               chk("misalign_err", misalign_err, q[0].mis);
               if (!q[0].mis) begin
                  chk("rf_waddr", rf_waddr, q[0].waddr);
                  chk("rf_wdata", rf_wdata, q[0].wdata);
               end
               if (!rf_stall && !flush) void'(q.pop_front());
            end
         end else if (q.size() != 0) begin
            chk("missing_out", 1'b0, 1'b1);
         end
`ifdef WB_RETIRE_CNT_EN
         chk("retire_cnt", retire_cnt, mcnt);
`endif
      end
   end

   initial begin
      logic [2:0] f3s [7];
      f3s = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3, 3'd6};
      mfull = 0;
      mcnt = '0;
      flush = 0;
      rf_stall = 0;
      set_in(0, 2'd0, 1'b1, 5'd0, 0, 32'h0, 3'd2, 2'd0);
      rst = 1'b1;
      #1;
      chk("reset_rf_we", rf_we, 1'b0);
      chk("reset_waddr", rf_waddr, 5'd0);
      chk("reset_wdata", rf_wdata, 32'h0);
      chk("reset_mis", misalign_err, 1'b0);
      chk("reset_ready", in_ready, 1'b1);
      tick(); tick();
      rst = 1'b0;

      // LB off=3, sign-extended byte
      set_in(1, 2'd2, 1'b1, 5'd5, 1, 32'h80FF_0000, 3'd0, 2'd3);
      tick();
      set_in(0, 2'd0, 1'b1, 5'd0, 0, 32'h0, 3'd2, 2'd0);
      chk("lb_we", rf_we, 1'b1);
      chk("lb_waddr", rf_waddr, 5'd5);
      chk("lb_wdata", rf_wdata, 32'hFFFF_FF80);

      // LHU off=2 then misaligned LH off=1
      set_in(1, 2'd2, 1'b1, 5'd6, 1, 32'hBEEF_1234, 3'd5, 2'd2);
      tick();
      chk("lhu_wdata", rf_wdata, 32'h0000_BEEF);
      set_in(1, 2'd2, 1'b1, 5'd6, 1, 32'hBEEF_1234, 3'd1, 2'd1);
      tick();
      set_in(0, 2'd0, 1'b1, 5'd0, 0, 32'h0, 3'd2, 2'd0);
      chk("lh_mis", misalign_err, 1'b1);
      chk("lh_mis_we", rf_we, 1'b0);

      // JAL link write, then ALU write to x0
      set_in(1, 2'd0, 1'b0, 5'd9, 1, 32'h0000_0104, 3'd2, 2'd0);
      tick();
      chk("jal_waddr", rf_waddr, 5'd1);
      chk("jal_wdata", rf_wdata, 32'h104);
      set_in(1, 2'd1, 1'b1, 5'd0, 1, 32'h1234_5678, 3'd2, 2'd0);
      tick();
      set_in(0, 2'd0, 1'b1, 5'd0, 0, 32'h0, 3'd2, 2'd0);
      chk("x0_we", rf_we, 1'b0);

      // Stall for three edges while the next entry waits
      set_in(1, 2'd1, 1'b1, 5'd7, 1, 32'h0000_AAAA, 3'd2, 2'd0);
      tick();
      set_in(1, 2'd1, 1'b1, 5'd8, 1, 32'h0000_BBBB, 3'd2, 2'd0);
      rf_stall = 1;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("stall_ready", in_ready, 1'b0);
         chk("stall_hold", rf_wdata, 32'h0000_AAAA);
         tick();
      end
      rf_stall = 0;
      tick();
      set_in(0, 2'd0, 1'b1, 5'd0, 0, 32'h0, 3'd2, 2'd0);
      chk("post_stall_waddr", rf_waddr, 5'd8);
      chk("post_stall_wdata", rf_wdata, 32'h0000_BBBB);

      // Flush during stall drops both held and incoming entries
      set_in(1, 2'd1, 1'b1, 5'd10, 1, 32'h0000_CCCC, 3'd2, 2'd0);
      tick();
      set_in(1, 2'd1, 1'b1, 5'd11, 1, 32'h0000_DDDD, 3'd2, 2'd0);
      rf_stall = 1;
      flush = 1;
      tick();
      chk("flush_we", rf_we, 1'b0);
      chk("flush_mis", misalign_err, 1'b0);
      flush = 0;
      rf_stall = 0;
      set_in(0, 2'd0, 1'b1, 5'd0, 0, 32'h0, 3'd2, 2'd0);
      tick();
      chk("flush_drop", rf_we, 1'b0);

      // Randomized traffic
      for (int n = 0; n < 3000; n++) begin
         set_in($urandom_range(0, 3) != 0, 2'($urandom), 1'($urandom), 5'($urandom),
                1'($urandom), $urandom, f3s[$urandom_range(0, 6)], 2'($urandom));
         in_pc4 = $urandom; in_alu = $urandom; in_csr = $urandom;
         rf_stall = ($urandom_range(0, 9) < 3);
         flush = ($urandom_range(0, 19) == 0);
         tick();
      end

      // Asynchronous reset mid-stream
      flush = 0;
      rf_stall = 0;
      set_in(1, 2'd1, 1'b1, 5'd12, 1, 32'h0000_EEEE, 3'd2, 2'd0);
      tick();
      set_in(0, 2'd0, 1'b1, 5'd0, 0, 32'h0, 3'd2, 2'd0);
      chk("pre_rst_we", rf_we, 1'b1);
      #2;
      do_reset_now();
      #1;
      chk("async_rst_we", rf_we, 1'b0);
      chk("async_rst_ready", in_ready, 1'b1);
`ifdef WB_RETIRE_CNT_EN
      chk("async_rst_cnt", retire_cnt, 64'd0);
`endif
      tick();
      rst = 1'b0;
      tick(); tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
